// File: rtl/uart_rx_word.sv
// 8N1 UART receiver that packs four consecutive frames (MSB of the word first) into a 32-bit word.
// Word appears one cycle after the 4th stop-bit sample; held with valid until ack, and overwritten (overrun flagged) if not acked in time.
module uart_rx_word #(
    parameter int BAUD_PRESCALER = 200,
    parameter int IDLE_TIMEOUT   = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        rx_pin,
    input  logic        ack,
    output logic [31:0] data,
    output logic        valid,
    output logic        busy,
    output logic        frame_err,
    output logic        overrun
);

    localparam int BAUD_W      = $clog2(BAUD_PRESCALER);
    localparam int TIMEOUT_CYC = IDLE_TIMEOUT * BAUD_PRESCALER;
    localparam int IDLE_W      = $clog2(TIMEOUT_CYC + 1);

    localparam logic [BAUD_W-1:0] HALF_BIT  = BAUD_W'(BAUD_PRESCALER / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL_BIT  = BAUD_W'(BAUD_PRESCALER - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic              sync1_q, sync2_q, prev_q;
    logic [1:0]        settle_q;
    logic              armed_q;
    logic              fall;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       shift_q, shift_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [31:0]       data_q, data_d;
    logic              valid_q, valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              baud_done;

    // Edges are only honoured once the synchronizer carries real pin data and
    // the line has been seen high, so a line held low across reset is ignored.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            prev_q   <= 1'b1;
            settle_q <= 2'd0;
            armed_q  <= 1'b0;
        end else begin
            sync1_q <= rx_pin;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (settle_q != 2'd2) begin
                settle_q <= settle_q + 2'd1;
            end
            if (settle_q == 2'd2 && sync2_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign fall      = armed_q & prev_q & ~sync2_q;
    assign baud_done = (baud_q == '0);

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_idx_d   = bit_idx_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        idle_d      = idle_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q;

        if (valid_q && ack) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                bit_idx_d = 3'd0;
                if (byte_cnt_q != 2'd0) begin
                    if (idle_q == IDLE_LAST) begin
                        byte_cnt_d = 2'd0;
                        idle_d     = '0;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end else begin
                    idle_d = '0;
                end
                if (fall) begin
                    state_d = START;
                    baud_d  = HALF_BIT;
                    idle_d  = '0;
                end
            end
            START: begin
                if (baud_done) begin
                    if (!sync2_q) begin
                        state_d   = DATA;
                        baud_d    = FULL_BIT;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    shift_d   = {shift_q[30:0], sync2_q};
                    baud_d    = FULL_BIT;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    state_d = IDLE;
                    if (sync2_q) begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        // A completion beats a same-cycle ack: the new word stays valid.
                        if (byte_cnt_q == 2'd3) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            if (valid_q && !ack) begin
                                overrun_d = 1'b1;
                            end
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        byte_cnt_d  = 2'd0;
                        shift_d     = '0;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_idx_q   <= 3'd0;
            byte_cnt_q  <= 2'd0;
            shift_q     <= '0;
            idle_q      <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_idx_q   <= bit_idx_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            idle_q      <= idle_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_word.sv
// Randomized and directed stimulus for uart_rx_word, checked against a byte-queue model of word assembly.
module tb_uart_rx_word;

    localparam int P  = 8;
    localparam int TO = 32;

    logic        i_clk  = 1'b0;
    logic        i_rst  = 1'b1;
    logic        rx_pin = 1'b1;
    logic        ack    = 1'b0;
    logic [31:0] data;
    logic        valid;
    logic        busy;
    logic        frame_err;
    logic        overrun;

    uart_rx_word #(
        .BAUD_PRESCALER(P),
        .IDLE_TIMEOUT  (TO)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .rx_pin   (rx_pin),
        .ack      (ack),
        .data     (data),
        .valid    (valid),
        .busy     (busy),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: bytes of the word in progress, plus expected outputs.
    logic [7:0]  part[$];
    logic [31:0] m_data = '0;
    logic        m_valid = 1'b0;
    logic        m_ovr   = 1'b0;
    int          m_ferr  = 0;
    int          ferr_cyc = 0;

    always @(negedge i_clk) begin
        if (frame_err) ferr_cyc++;
    end

    task automatic model_reset();
        part.delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit ack_at_done, output bit done);
        done = 1'b0;
        if (!stop_ok) begin
            part.delete();
            m_ferr++;
        end else begin
            part.push_back(b);
            if (part.size() == 4) begin
                if (m_valid && !ack_at_done) m_ovr = 1'b1;
                m_data  = {part[0], part[1], part[2], part[3]};
                m_valid = 1'b1;
                part.delete();
                done = 1'b1;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit ack_at_done);
        logic [9:0] bits;
        int first_busy;
        bits = {1'b0, b, stop_ok};
        first_busy = -1;
        for (int c = 0; c < 10 * P; c++) begin
            rx_pin = bits[9 - c / P];
            if (busy && first_busy < 0) first_busy = c;
            // Stop-bit sample cycle: edge detection precedes the first busy cycle by one,
            // the start sample follows P/2 later, the stop sample 9 bit-times after that.
            if (ack_at_done) ack = (first_busy >= 0) && (c == first_busy + P / 2 + 9 * P - 1);
            @(negedge i_clk);
        end
        ack = 1'b0;
    endtask

    task automatic idle_bits(input int n);
        rx_pin = 1'b1;
        repeat (n * P) @(negedge i_clk);
        if (n > TO) part.delete();
    endtask

    task automatic tx(input string tag, input logic [7:0] b, input bit stop_ok, input bit ack_at_done, output bit done);
        send_frame(b, stop_ok, ack_at_done);
        model_frame(b, stop_ok, ack_at_done, done);
        chk({tag, "_ferr"}, ferr_cyc, m_ferr);
        chk({tag, "_valid"}, valid, m_valid);
        chk({tag, "_data"}, data, m_data);
        chk({tag, "_ovr"}, overrun, m_ovr);
    endtask

    task automatic tx_word(input string tag, input logic [31:0] w, input int gap, input bit ack_last);
        bit done;
        for (int i = 0; i < 4; i++) begin
            tx(tag, w[31 - 8 * i -: 8], 1'b1, ack_last && i == 3, done);
            if (gap > 0) idle_bits(gap);
        end
    endtask

    task automatic do_ack(input string tag);
        ack = 1'b1;
        @(negedge i_clk);
        ack = 1'b0;
        m_valid = 1'b0;
        chk({tag, "_ackclr"}, valid, 1'b0);
    endtask

    task automatic apply_reset(input string tag);
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        chk({tag, "_rst_data"}, data, 32'h0);
        chk({tag, "_rst_flags"}, {valid, busy, frame_err, overrun}, 4'b0000);
        i_rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        @(negedge i_clk);
        apply_reset("init");
        idle_bits(2);

        tx_word("nominal", 32'hDEADBEEF, 1, 1'b0);
        do_ack("nominal");

        tx("glitch_a", 8'h5A, 1'b1, 1'b0, done);
        idle_bits(1);
        tx("glitch_b", 8'hC3, 1'b1, 1'b0, done);
        idle_bits(1);
        rx_pin = 1'b0;
        repeat (2) @(negedge i_clk);
        idle_bits(2);
        chk("glitch_busy", busy, 1'b0);
        chk("glitch_ferr", ferr_cyc, m_ferr);
        chk("glitch_valid", valid, 1'b0);
        tx("glitch_c", 8'h96, 1'b1, 1'b0, done);
        tx("glitch_d", 8'h0F, 1'b1, 1'b0, done);
        chk("glitch_word", data, 32'h5AC3960F);
        do_ack("glitch");

        tx("ferr_a", 8'h12, 1'b1, 1'b0, done);
        tx("ferr_b", 8'h34, 1'b0, 1'b0, done);
        idle_bits(1);
        tx_word("ferr_w", 32'h11223344, 0, 1'b0);
        do_ack("ferr");

        tx("to_a", 8'hAA, 1'b1, 1'b0, done);
        tx("to_b", 8'hBB, 1'b1, 1'b0, done);
        idle_bits(TO + 1);
        tx_word("to_w", 32'h01020304, 0, 1'b0);
        do_ack("to");

        tx_word("ovr1", 32'h13579BDF, 0, 1'b0);
        tx_word("ovr2", 32'h2468ACE0, 1, 1'b0);

        apply_reset("sim");
        idle_bits(1);
        tx_word("sim1", 32'hA5A55A5A, 0, 1'b0);
        tx_word("sim2", 32'h0BADF00D, 0, 1'b1);
        @(negedge i_clk);
        chk("sim_hold", valid, 1'b1);

        tx("mid_a", 8'h77, 1'b1, 1'b0, done);
        rx_pin = 1'b0;
        repeat (5 * P + P / 2) @(negedge i_clk);
        apply_reset("mid");
        repeat (2 * P) @(negedge i_clk);
        chk("mid_lowrel_busy", busy, 1'b0);
        idle_bits(2);
        tx_word("mid_w", 32'hCAFEF00D, 0, 1'b0);
        do_ack("mid");

        apply_reset("rnd");
        idle_bits(1);
        for (int i = 0; i < 28; i++) begin
            logic [7:0] b;
            bit ok;
            int r, gap;
            b  = 8'($urandom);
            ok = ($urandom_range(0, 7) != 0);
            tx("rnd", b, ok, 1'b0, done);
            if (done && $urandom_range(0, 1) == 1) do_ack("rnd");
            r = $urandom_range(0, 9);
            gap = (r == 0) ? 40 : (r < 4) ? 0 : (r < 7) ? 1 : 2;
            if (!ok && gap == 0) gap = 1;
            idle_bits(gap);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
